// File: rtl/serial_char_link.sv
// serial_char_link: byte-wide async serial link, independent TX and RX.
// Define SERIAL_PARITY_EN for an even-parity bit (11-bit frames).
`timescale 1ns/1ps
module serial_char_link #(
  parameter int CLK_DIV = 5208
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] tx_data,
  input  logic       load_i,
  input  logic       trans_en,
  output logic       char_sent,
  output logic [7:0] bus_in,
  output logic       char_rec,
  output logic       serial_tx,
  input  logic       serial_rx
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
  localparam state_t S_AFTER = S_PARITY;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
  localparam state_t S_AFTER = S_STOP;
`endif

  state_t      tx_st, tx_nx;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic [7:0]  hold;
  logic        pending;
  logic        load_q;
  logic        load_rise;
  logic        tx_end;
  logic        tx_go;
  logic        tx_load;
  logic        tx_line;
`ifdef SERIAL_PARITY_EN
  logic        tx_par;
`endif

  assign load_rise = load_i & ~load_q;
  assign tx_end    = (tx_cnt == DIV_M1);
  assign tx_go     = pending & trans_en;
  assign tx_load   = tx_go &
                     ((tx_st == S_IDLE) |
                      ((tx_st == S_STOP) & tx_end));

  // TX next state and the line level for the current state
  always_comb begin
    tx_nx   = tx_st;
    tx_line = 1'b1;
    unique case (tx_st)
      S_IDLE: begin
        if (tx_go) tx_nx = S_START;
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_end) tx_nx = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_sh[0];
        if (tx_end && tx_bit == 3'd7)
          tx_nx = S_AFTER;
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        tx_line = tx_par;
        if (tx_end) tx_nx = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_end)
          tx_nx = tx_go ? S_START : S_IDLE;
      end
      default: tx_nx = S_IDLE;
    endcase
  end

  // TX registers: load capture, shifter, bit timer, line
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_st     <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      hold      <= '0;
      pending   <= 1'b0;
      load_q    <= 1'b0;
      char_sent <= 1'b0;
      serial_tx <= 1'b1;
`ifdef SERIAL_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      load_q    <= load_i;
      tx_st     <= tx_nx;
      serial_tx <= tx_line;
      if (tx_st == S_IDLE || tx_end)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 16'd1;
      if (tx_st == S_DATA && tx_end) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
      if (tx_load) begin
        tx_sh  <= hold;
        tx_bit <= '0;
`ifdef SERIAL_PARITY_EN
        tx_par <= ^hold;
`endif
      end
      if (load_rise) begin
        hold    <= tx_data;
        pending <= 1'b1;
      end else if (tx_load) begin
        pending <= 1'b0;
      end
      if (load_rise)
        char_sent <= 1'b0;
      else if (tx_st == S_STOP && tx_end)
        char_sent <= 1'b1;
    end
  end

  state_t      rx_st, rx_nx;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_s1, rx_s2, rx_q;
  logic        rx_fall;
  logic        rx_end;
  logic        rx_half;
  logic        rx_ok;
`ifdef SERIAL_PARITY_EN
  logic        rx_pbit;
`endif

  assign rx_fall = rx_q & ~rx_s2;
  assign rx_end  = (rx_cnt == DIV_M1);
  assign rx_half = (rx_cnt == HALF_M1);
`ifdef SERIAL_PARITY_EN
  assign rx_ok   = rx_s2 & ((^rx_sh) == rx_pbit);
`else
  assign rx_ok   = rx_s2;
`endif

  // RX next state; a high start sample is a glitch
  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      S_IDLE: begin
        if (rx_fall) rx_nx = S_START;
      end
      S_START: begin
        if (rx_half)
          rx_nx = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_end && rx_bit == 3'd7)
          rx_nx = S_AFTER;
      end
`ifdef SERIAL_PARITY_EN
      S_PARITY: begin
        if (rx_end) rx_nx = S_STOP;
      end
`endif
      S_STOP: begin
        if (rx_end) rx_nx = S_IDLE;
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  // RX registers: synchroniser, mid-bit sampler, result
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_q     <= 1'b1;
      rx_st    <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      bus_in   <= '0;
      char_rec <= 1'b0;
`ifdef SERIAL_PARITY_EN
      rx_pbit  <= 1'b0;
`endif
    end else begin
      rx_s1    <= serial_rx;
      rx_s2    <= rx_s1;
      rx_q     <= rx_s2;
      rx_st    <= rx_nx;
      char_rec <= 1'b0;
      if (rx_st == S_IDLE || rx_nx != rx_st || rx_end)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_st == S_IDLE)
        rx_bit <= '0;
      if (rx_st == S_DATA && rx_end) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
`ifdef SERIAL_PARITY_EN
      if (rx_st == S_PARITY && rx_end)
        rx_pbit <= rx_s2;
`endif
      if (rx_st == S_STOP && rx_end && rx_ok) begin
        bus_in   <= rx_sh;
        char_rec <= 1'b1;
      end
    end
  end

endmodule

// File: doc/serial_char_link.md
SERIAL_CHAR_LINK -- requirements
Module: serial_char_link

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, clock cycles per serial bit period (legal range 4..65535).
REQ-002 SHALL have port clk_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, character from the processor output bus.
REQ-005 SHALL have port load_i, input, 1, level from the processor; a rising edge captures tx_data.
REQ-006 SHALL have port trans_en, input, 1, transmit enable level.
REQ-007 SHALL have port char_sent, output, 1, sticky flag: last loaded character has fully left the line.
REQ-008 SHALL have port bus_in, output, 8, last correctly received character.
REQ-009 SHALL have port char_rec, output, 1, one-cycle pulse on each valid reception.
REQ-010 SHALL have port serial_tx, output, 1, serial line out, idle high.
REQ-011 SHALL have port serial_rx, input, 1, asynchronous serial line in, idle high.

Function
REQ-012 SHALL transmit frames as: start bit 0, 8 data bits LSB first, optional parity bit (REQ-030), stop bit 1; each bit held exactly CLK_DIV cycles.
REQ-013 SHALL edge-detect load_i (registered previous value); on rising edge, tx_data goes to a holding register, pending set, and char_sent cleared in the same cycle.
REQ-014 SHALL use TX states IDLE, START, DATA, PARITY, STOP; IDLE->START when pending=1 and trans_en=1, clearing pending and copying the holding register into the shift register.
REQ-015 SHALL drive serial_tx from a register, so the first start-bit cycle appears one clock after the IDLE->START transition.
REQ-016 SHALL ignore trans_en deassertion mid-frame; the frame completes.
REQ-017 SHALL let a load_i rising edge during a frame update the holding register and set pending without corrupting the frame in flight; that character is sent afterwards.
REQ-018 SHALL set char_sent in the last cycle of STOP unless a load_i rising edge occurs in that same cycle (load wins: char_sent stays 0).
REQ-019 SHALL allow back-to-back frames: STOP->START directly when pending=1 and trans_en=1, with no extra idle bit.
REQ-020 SHALL synchronise serial_rx through two flip-flops before any use.
REQ-021 SHALL use RX states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised 1->0 transition.
REQ-022 SHALL sample at mid-bit (CLK_DIV/2 cycles into START, then every CLK_DIV); a start sample of 1 returns to IDLE (glitch reject).
REQ-023 SHALL, at the stop-bit sample, if the sample is 1 (and parity is OK when enabled), load bus_in and pulse char_rec for exactly one cycle, then enter IDLE.
REQ-024 SHALL, if the stop sample is 0, discard the character (bus_in unchanged, no pulse) and wait in IDLE for the line to return to 1 before re-arming.
REQ-025 SHALL run TX and RX independently; simultaneous TX and RX (including loopback serial_tx->serial_rx) SHALL work.

Reset
REQ-026 SHALL, on reset_reset_n low, immediately and asynchronously force serial_tx=1, char_sent=0, char_rec=0, bus_in=8'h00, pending=0, both FSMs to IDLE, all counters to 0.
REQ-027 SHALL abort any frame in progress on reset without emitting further bits; synchroniser flops reset to 1.
REQ-028 SHALL require no cycles after deassertion before accepting load_i.

Configuration
REQ-029 SHALL use macro SERIAL_PARITY_EN to select the parity feature.
REQ-030 SHALL, with SERIAL_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) after data (11-bit frame); the receiver discards characters with parity mismatch exactly as in REQ-024.
REQ-031 SHALL, without SERIAL_PARITY_EN, omit the PARITY states entirely (10-bit frame) and contain no parity logic.

Verification (CLK_DIV=4)
REQ-032 SHALL cover: tx_data=8'hA5, load_i pulse, trans_en=1 -> serial_tx 0,1,0,1,0,0,1,0,1,1 in 4-cycle bits; char_sent=1 after stop.
REQ-033 SHALL cover: loopback, send 8'h3C then 8'hC3 back-to-back -> char_rec pulses twice (1 cycle each), bus_in 8'h3C then 8'hC3, no idle gap on serial_tx.
REQ-034 SHALL cover: serial_rx low for 1 cycle only -> no char_rec, RX back in IDLE, bus_in unchanged.
REQ-035 SHALL cover: frame with stop bit 0 (and, with SERIAL_PARITY_EN, wrong parity on 8'h01) -> no char_rec, bus_in retains previous value.
REQ-036 SHALL cover: reset_reset_n low mid-DATA -> serial_tx=1 in the same cycle, char_sent=0; after release, a new 8'h55 transmits correctly.
REQ-037 SHALL cover: trans_en=0 with load of 8'h11 -> serial_tx stays 1; raising trans_en sends 8'h11.
